dma_read_splitter: RTL and testbench
====================================

DMA_READ_SPLITTER -- requirements
Module: dma_read_splitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, data beat width in bits (power of two, >=64); BEAT_BYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter MAX_BURST_BYTES, default 4096, maximum bytes per read command; power of two, multiple of BEAT_BYTES.
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, transfer request valid.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_address, input, 64, transfer start byte address.
REQ-008 SHALL have port req_length, input, 32, transfer length in bytes.
REQ-009 SHALL have ports read_cmd_valid (output, 1), read_cmd_ready (input, 1), read_cmd_address (output, 64) and read_cmd_length (output, 32), forming the DMA read command stream.
REQ-010 SHALL have ports read_data_valid (input, 1), read_data_ready (output, 1), read_data_data (input, DATA_WIDTH), read_data_keep (input, DATA_WIDTH/8) and read_data_last (input, 1), forming the DMA read data stream.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_WIDTH), out_keep (output, DATA_WIDTH/8) and out_last (output, 1), forming the consumer stream.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at transfer completion.

Function
REQ-013 SHALL ignore the low log2(BEAT_BYTES) bits of req_address and req_length, treating both as beat-aligned.
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE; req_ready = 1 only in IDLE.
REQ-015 SHALL, on request accept in IDLE, latch address, remaining command bytes = aligned length, and expected beats = aligned length / BEAT_BYTES; go to RUN, or to DONE if length is 0.
REQ-016 SHALL, in RUN while remaining command bytes > 0, assert read_cmd_valid with address = current address; length = min(remaining, MAX_BURST_BYTES - (address mod MAX_BURST_BYTES)), so no command crosses a MAX_BURST_BYTES boundary.
REQ-017 SHALL hold read_cmd_address/length stable while read_cmd_valid=1 and read_cmd_ready=0.
REQ-018 SHALL, on read_cmd fire, advance address by, and reduce remaining by, the issued length; next command is presented the following cycle; no command issued after remaining reaches 0.
REQ-019 SHALL issue commands independently of data progress; commands and data overlap.
REQ-020 SHALL pass data combinationally: out_valid = read_data_valid & (state==RUN), read_data_ready = out_ready & (state==RUN), out_data/out_keep = read_data_data/read_data_keep.
REQ-021 SHALL ignore read_data_last; out_last = out_valid & (beats remaining == 1).
REQ-022 SHALL decrement beats remaining on each out fire; on the fire with beats remaining == 1 go to DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE; req_ready rises the cycle after done.
REQ-024 SHALL drop read_data beats arriving in IDLE/DONE by holding read_data_ready=0 (not consumed).
REQ-025 SHALL compute address arithmetic in 64 bits, with wrap at 2^64, and counters in 32 bits.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, all counters 0, req_ready=0, read_cmd_valid=0, read_data_ready=0, out_valid=0, out_last=0 and done=0; req_ready=1 the first cycle after reset deasserts.
REQ-027 SHALL abandon any in-flight transfer on reset with no further commands or done.

Verification (DATA_WIDTH=512, MAX_BURST_BYTES=4096)
REQ-028 SHALL cover: req (0x0, 256) -> one cmd (0x0, 256); 4 out beats, out_last on the 4th; done the next cycle.
REQ-029 SHALL cover: req (0xF00, 512) -> cmds (0xF00, 256) then (0x1000, 256); 8 beats, out_last on the 8th only.
REQ-030 SHALL cover: req (0x0, 12288), read_cmd_ready low for 5 cycles -> 3 cmds of 4096 at 0x0, 0x1000 and 0x2000, stable while stalled; 192 beats.
REQ-031 SHALL cover: random out_ready toggling with a 10-cycle DMA read delay -> all beats delivered in order, none lost or duplicated.
REQ-032 SHALL cover: req (0x40, 0) -> no cmd, done 1 cycle after accept; reset asserted mid-RUN -> all outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/dma_read_splitter.sv
// Splits one DMA read transfer into burst-boundary-safe read commands and
// forwards the returned beats to the consumer, pulsing done after the last one.
module dma_read_splitter #(
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_BURST_BYTES = 4096
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [63:0]             req_address,
   input  logic [31:0]             req_length,
   output logic                    read_cmd_valid,
   input  logic                    read_cmd_ready,
   output logic [63:0]             read_cmd_address,
   output logic [31:0]             read_cmd_length,
   input  logic                    read_data_valid,
   output logic                    read_data_ready,
   input  logic [DATA_WIDTH-1:0]   read_data_data,
   input  logic [DATA_WIDTH/8-1:0] read_data_keep,
   input  logic                    read_data_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [DATA_WIDTH/8-1:0] out_keep,
   output logic                    out_last,
   output logic                    done
);

   localparam int BEAT_BYTES  = DATA_WIDTH / 8;
   localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
   localparam int BURST_SHIFT = $clog2(MAX_BURST_BYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   logic [63:0] r_address;
   logic [31:0] r_cmdRemaining;
   logic [31:0] r_beatsRemaining;

   logic [63:0] w_reqAddrAligned;
   logic [31:0] w_reqLenAligned;
   logic [31:0] w_burstOffset;
   logic [31:0] w_burstRoom;
   logic [31:0] w_cmdLength;
   logic        w_run;
   logic        w_cmdFire;
   logic        w_outFire;
   logic        w_unusedLast;

   assign w_reqAddrAligned = req_address & ~64'(BEAT_BYTES - 1);
   assign w_reqLenAligned  = req_length & ~32'(BEAT_BYTES - 1);

   // Bytes left before the next burst boundary caps each command's length
   assign w_burstOffset = {{(32 - BURST_SHIFT){1'b0}}, r_address[BURST_SHIFT-1:0]};
   assign w_burstRoom   = 32'(MAX_BURST_BYTES) - w_burstOffset;
   assign w_cmdLength   = (r_cmdRemaining < w_burstRoom) ? r_cmdRemaining : w_burstRoom;

   assign w_run     = (r_state == RUN) & ~reset;
   assign w_cmdFire = read_cmd_valid & read_cmd_ready;
   assign w_outFire = out_valid & out_ready;

   assign req_ready        = (r_state == IDLE) & ~reset;
   assign done             = (r_state == DONE) & ~reset;
   assign read_cmd_valid   = w_run & (r_cmdRemaining != 32'd0);
   assign read_cmd_address = r_address;
   assign read_cmd_length  = w_cmdLength;

   // The beat count comes from the request, so the source's last flag is not needed
   assign w_unusedLast    = read_data_last;
   assign out_valid       = read_data_valid & w_run;
   assign read_data_ready = out_ready & w_run;
   assign out_data        = read_data_data;
   assign out_keep        = read_data_keep;
   assign out_last        = out_valid & (r_beatsRemaining == 32'd1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= IDLE;
         r_address        <= 64'd0;
         r_cmdRemaining   <= 32'd0;
         r_beatsRemaining <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_address        <= w_reqAddrAligned;
                  r_cmdRemaining   <= w_reqLenAligned;
                  r_beatsRemaining <= req_length >> BEAT_SHIFT;
                  r_state          <= (w_reqLenAligned == 32'd0) ? DONE : RUN;
               end
            end
            RUN: begin
               // Command issue and data delivery progress independently
               if (w_cmdFire) begin
                  r_address      <= r_address + 64'(w_cmdLength);
                  r_cmdRemaining <= r_cmdRemaining - w_cmdLength;
               end
               if (w_outFire) begin
                  r_beatsRemaining <= r_beatsRemaining - 32'd1;
                  if (r_beatsRemaining == 32'd1) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_read_splitter.sv
// Self-checking bench for dma_read_splitter: a delayed DMA memory model feeds
// beats back, and queued expected commands/beats are compared as they appear.
module tb_dma_read_splitter;

   localparam int DW = 512;
   localparam int BB = DW / 8;
   localparam int MB = 4096;

   logic          clock;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_address;
   logic [31:0]   req_length;
   logic          read_cmd_valid;
   logic          read_cmd_ready;
   logic [63:0]   read_cmd_address;
   logic [31:0]   read_cmd_length;
   logic          read_data_valid;
   logic          read_data_ready;
   logic [DW-1:0] read_data_data;
   logic [BB-1:0] read_data_keep;
   logic          read_data_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [BB-1:0] out_keep;
   logic          out_last;
   logic          done;

   dma_read_splitter #(.DATA_WIDTH(DW), .MAX_BURST_BYTES(MB)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_address(req_address), .req_length(req_length),
      .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
      .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
      .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
      .read_data_data(read_data_data), .read_data_keep(read_data_keep),
      .read_data_last(read_data_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_last(out_last), .done(done)
   );

   typedef struct packed {logic [63:0] addr; logic [31:0] len;} cmd_t;
   typedef struct packed {logic [63:0] addr; logic last;} beat_t;
   typedef struct {logic [63:0] addr; logic [31:0] len; int readyAt;} dma_t;

   cmd_t  expCmdQ[$];
   beat_t expBeatQ[$];
   dma_t  dmaQ[$];
   cmd_t  expCmd;
   beat_t expBeat;
   dma_t  dmaHead;

   int passCount = 0;
   int checkCount = 0;
   int cycle = 0;
   int cmdFireCount = 0;
   int beatCount = 0;
   int doneCount = 0;
   int stalledCycles = 0;
   int lastFireCycle = -1;
   int acceptCycle = -1;
   int doneCycle = -1;

   bit          randomReady = 0;
   int          cmdStallLeft = 0;
   bit          beatFired = 0;
   bit          active = 0;
   logic [63:0] curAddr = 64'd0;
   int          beatsLeft = 0;
   bit          prevStalled = 0;
   logic [63:0] prevAddr;
   logic [31:0] prevLen;

   function automatic logic [DW-1:0] beatData(input logic [63:0] a);
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 64; i++) begin
         d[i*64 +: 64] = a ^ (64'(i) << 56) ^ 64'h005A_0000_0000_0000;
      end
      return d;
   endfunction

   function automatic logic [BB-1:0] beatKeep(input logic [63:0] a);
      return {a[37:6], ~a[37:6]};
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   // DMA memory model: returns each accepted command's beats ten cycles later
   initial begin
      read_data_valid = 1'b0;
      read_data_data  = '0;
      read_data_keep  = '0;
      read_data_last  = 1'b0;
      read_cmd_ready  = 1'b1;
      out_ready       = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         if (beatFired) begin
            beatFired = 0;
            curAddr   = curAddr + 64'(BB);
            beatsLeft--;
            if (beatsLeft == 0) active = 0;
         end
         if (!active && dmaQ.size() > 0 && cycle >= dmaQ[0].readyAt) begin
            dmaHead   = dmaQ.pop_front();
            curAddr   = dmaHead.addr;
            beatsLeft = int'(dmaHead.len) / BB;
            active    = (beatsLeft != 0);
         end
         read_data_valid = active;
         read_data_data  = beatData(curAddr);
         read_data_keep  = beatKeep(curAddr);
         read_data_last  = active && (beatsLeft == 1);
         out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cmdStallLeft > 0) begin
            read_cmd_ready = 1'b0;
            cmdStallLeft--;
         end else begin
            read_cmd_ready = 1'b1;
         end
      end
   end

   // Scoreboard side: every handshake is compared against the queued expectation
   always @(negedge clock) begin
      if (!reset) begin
         if (read_cmd_valid && read_cmd_ready) begin
            cmdFireCount++;
            checkCount++;
            if (expCmdQ.size() == 0) begin
               $display("[TB] FAIL cmd_unexpected got addr=%h len=%0d required no command",
                        read_cmd_address, read_cmd_length);
            end else begin
               expCmd = expCmdQ.pop_front();
               if (read_cmd_address === expCmd.addr && read_cmd_length === expCmd.len)
                  passCount++;
               else
                  $display("[TB] FAIL cmd got addr=%h len=%0d required addr=%h len=%0d",
                           read_cmd_address, read_cmd_length, expCmd.addr, expCmd.len);
            end
            dmaQ.push_back('{read_cmd_address, read_cmd_length, cycle + 11});
         end
         if (prevStalled) begin
            checkCount++;
            if (read_cmd_valid === 1'b1 && read_cmd_address === prevAddr && read_cmd_length === prevLen)
               passCount++;
            else
               $display("[TB] FAIL cmd_stable got valid=%b addr=%h len=%0d required valid=1 addr=%h len=%0d",
                        read_cmd_valid, read_cmd_address, read_cmd_length, prevAddr, prevLen);
         end
         prevStalled = read_cmd_valid && !read_cmd_ready;
         if (prevStalled) stalledCycles++;
         prevAddr = read_cmd_address;
         prevLen  = read_cmd_length;
         if (read_data_valid && read_data_ready) beatFired = 1;
         if (out_valid && out_ready) begin
            beatCount++;
            if (expBeatQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL beat_unexpected got keep=%h required no beat", out_keep);
            end else begin
               expBeat = expBeatQ.pop_front();
               checkCount++;
               if (out_data === beatData(expBeat.addr) && out_keep === beatKeep(expBeat.addr))
                  passCount++;
               else
                  $display("[TB] FAIL beat_data got keep=%h data[63:0]=%h required keep=%h data[63:0]=%h",
                           out_keep, out_data[63:0], beatKeep(expBeat.addr), beatData(expBeat.addr) & 512'hFFFF_FFFF_FFFF_FFFF);
               checkCount++;
               if (out_last === expBeat.last) passCount++;
               else $display("[TB] FAIL beat_last got %b required %b", out_last, expBeat.last);
            end
            if (out_last) lastFireCycle = cycle;
         end
         if (done) doneCount++;
      end else begin
         prevStalled = 0;
      end
   end

   task automatic sendRequest(input logic [63:0] a, input logic [31:0] l);
      logic [63:0] addr;
      logic [31:0] rem;
      logic [31:0] room;
      logic [31:0] len;
      int          beats;
      bit          got;
      addr = a & ~64'(BB - 1);
      rem  = l & ~32'(BB - 1);
      beats = int'(rem) / BB;
      for (int i = 0; i < beats; i++) begin
         expBeatQ.push_back('{addr + 64'(i * BB), (i == beats - 1)});
      end
      while (rem != 0) begin
         room = 32'(MB) - 32'(addr % 64'(MB));
         len  = (rem < room) ? rem : room;
         expCmdQ.push_back('{addr, len});
         addr = addr + 64'(len);
         rem  = rem - len;
      end
      @(posedge clock);
      #1;
      req_valid   = 1'b1;
      req_address = a;
      req_length  = l;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (req_ready === 1'b1) begin
            got = 1;
            acceptCycle = cycle;
            break;
         end
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      checkCount++;
      if (got) passCount++;
      else $display("[TB] FAIL req_accept got req_ready=0 for 100 cycles required 1");
   endtask

   task automatic waitDone(input string name, input int budget);
      bit found;
      found = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            found = 1;
            break;
         end
      end
      checkCount++;
      if (found) passCount++;
      else $display("[TB] FAIL %s_done got no done in %0d cycles required done", name, budget);
      if (found) begin
         doneCycle = cycle;
         @(negedge clock);
         checkCount++;
         if (done === 1'b0 && req_ready === 1'b1) passCount++;
         else $display("[TB] FAIL %s_after_done got done=%b req_ready=%b required done=0 req_ready=1",
                       name, done, req_ready);
      end
      checkCount++;
      if (expCmdQ.size() == 0 && expBeatQ.size() == 0) passCount++;
      else $display("[TB] FAIL %s_drain got %0d cmds %0d beats outstanding required 0 0",
                    name, expCmdQ.size(), expBeatQ.size());
   endtask

   task automatic checkIdleOutputs(input string name);
      checkCount++;
      if (req_ready === 1'b0 && read_cmd_valid === 1'b0 && read_data_ready === 1'b0 &&
          out_valid === 1'b0 && out_last === 1'b0 && done === 1'b0)
         passCount++;
      else
         $display("[TB] FAIL %s got req_ready=%b cmd_valid=%b rd_ready=%b out_valid=%b out_last=%b done=%b required all 0",
                  name, req_ready, read_cmd_valid, read_data_ready, out_valid, out_last, done);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkIdleOutputs("reset_outputs");
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkCount++;
      if (req_ready === 1'b1) passCount++;
      else $display("[TB] FAIL reset_release_ready got %b required 1", req_ready);
   endtask

   task automatic test_single();
      int c0, b0;
      c0 = cmdFireCount;
      b0 = beatCount;
      sendRequest(64'h0, 32'd256);
      waitDone("single", 200);
      checkCount++;
      if (cmdFireCount - c0 == 1 && beatCount - b0 == 4) passCount++;
      else $display("[TB] FAIL single_counts got cmds=%0d beats=%0d required 1 4", cmdFireCount - c0, beatCount - b0);
      checkCount++;
      if (doneCycle == lastFireCycle + 1) passCount++;
      else $display("[TB] FAIL single_done_latency got %0d required %0d", doneCycle - lastFireCycle, 1);
   endtask

   task automatic test_boundary();
      int c0, b0;
      c0 = cmdFireCount;
      b0 = beatCount;
      sendRequest(64'hF00, 32'd512);
      waitDone("boundary", 200);
      checkCount++;
      if (cmdFireCount - c0 == 2 && beatCount - b0 == 8) passCount++;
      else $display("[TB] FAIL boundary_counts got cmds=%0d beats=%0d required 2 8", cmdFireCount - c0, beatCount - b0);
   endtask

   task automatic test_cmd_stall();
      int c0, b0, s0;
      c0 = cmdFireCount;
      b0 = beatCount;
      s0 = stalledCycles;
      cmdStallLeft = 8;
      sendRequest(64'h0, 32'd12288);
      waitDone("stall", 1000);
      checkCount++;
      if (cmdFireCount - c0 == 3 && beatCount - b0 == 192) passCount++;
      else $display("[TB] FAIL stall_counts got cmds=%0d beats=%0d required 3 192", cmdFireCount - c0, beatCount - b0);
      checkCount++;
      if (stalledCycles - s0 >= 5) passCount++;
      else $display("[TB] FAIL stall_cycles got %0d required at least 5", stalledCycles - s0);
   endtask

   task automatic test_random_ready();
      int c0, b0;
      c0 = cmdFireCount;
      b0 = beatCount;
      randomReady = 1;
      sendRequest(64'h1F4B, 32'd5000);
      waitDone("random", 2000);
      randomReady = 0;
      checkCount++;
      if (cmdFireCount - c0 == 3 && beatCount - b0 == 78) passCount++;
      else $display("[TB] FAIL random_counts got cmds=%0d beats=%0d required 3 78", cmdFireCount - c0, beatCount - b0);
   endtask

   task automatic test_zero_length();
      int c0;
      c0 = cmdFireCount;
      sendRequest(64'h40, 32'd0);
      waitDone("zero", 20);
      checkCount++;
      if (doneCycle == acceptCycle + 1 && cmdFireCount == c0) passCount++;
      else $display("[TB] FAIL zero_done got latency=%0d cmds=%0d required 1 0", doneCycle - acceptCycle, cmdFireCount - c0);
   endtask

   task automatic test_reset_mid_run();
      int  b0, c0, d0;
      bit  reached;
      b0 = beatCount;
      sendRequest(64'h0, 32'd8192);
      reached = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (beatCount - b0 >= 5) begin
            reached = 1;
            break;
         end
      end
      checkCount++;
      if (reached) passCount++;
      else $display("[TB] FAIL midrun_progress got %0d beats required 5", beatCount - b0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      checkIdleOutputs("midrun_reset_outputs");
      dmaQ.delete();
      expCmdQ.delete();
      expBeatQ.delete();
      active    = 0;
      beatsLeft = 0;
      beatFired = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkCount++;
      if (req_ready === 1'b1) passCount++;
      else $display("[TB] FAIL midrun_release_ready got %b required 1", req_ready);
      c0 = cmdFireCount;
      d0 = doneCount;
      repeat (30) @(negedge clock);
      checkCount++;
      if (cmdFireCount == c0 && doneCount == d0) passCount++;
      else $display("[TB] FAIL midrun_abandon got cmds=%0d dones=%0d required 0 0", cmdFireCount - c0, doneCount - d0);
   endtask

   task automatic test_back_to_back();
      int c0, b0;
      c0 = cmdFireCount;
      b0 = beatCount;
      sendRequest(64'h100, 32'd128);
      waitDone("b2b_first", 200);
      sendRequest(64'hFC0, 32'd192);
      waitDone("b2b_second", 200);
      checkCount++;
      if (cmdFireCount - c0 == 3 && beatCount - b0 == 5) passCount++;
      else $display("[TB] FAIL b2b_counts got cmds=%0d beats=%0d required 3 5", cmdFireCount - c0, beatCount - b0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got simulation still running required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_address = 64'd0;
      req_length  = 32'd0;
      test_reset();
      test_single();
      test_boundary();
      test_cmd_stall();
      test_random_ready();
      test_zero_length();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
